branch_predict_resolver: RTL and testbench
==========================================

Name: branch_predict_resolver

Overview:
- Parametrised successor to the single-cycle jump-flush logic.
- Holds a pattern history table (PHT) of saturating counters, indexed by PC, that supplies taken/not-taken predictions to fetch.
- Resolves branches and jumps in execute: detects mispredictions, generates the redirect PC and the decode/execute flushes, and defers a redirect that collides with a decode stall.
- Keeps branch and mispredict performance counters.

Parameters:
- XLEN, 32, address/data width.
- PHT_ENTRIES, 64, number of counters; must be a power of two and at least 2.
- IDX_LSB, 2, lowest PC bit used in the PHT index (index = pc[IDX_LSB +: log2(PHT_ENTRIES)]).
- CNT_W, 2, counter width; must be at least 2.
- PERF_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- pc_f  input  XLEN  fetch PC used for the PHT lookup
- pred_taken_f  output  1  MSB of PHT[idx(pc_f)]; combinational read
- ex_valid  input  1  execute holds a resolving control-flow instruction
- ex_is_branch  input  1  conditional branch
- ex_is_jump  input  1  unconditional jump (JAL/JALR)
- ex_taken  input  1  actual branch outcome
- ex_pred_taken  input  1  prediction carried down the pipe from fetch
- ex_pc  input  XLEN  PC of the resolving instruction
- ex_target  input  XLEN  computed taken target
- ex_pc_plus4  input  XLEN  fall-through PC
- stall_d  input  1  decode stall
- flag  output  1  redirect valid this cycle
- redirect_pc  output  XLEN  PC to load into fetch when flag=1
- flush_d  output  1  flush decode register
- flush_e  output  1  flush execute register
- branch_count  output  PERF_W  accepted conditional branches
- mispredict_count  output  PERF_W  accepted mispredicts (branch or jump)

Behaviour:
- Reset (async, immediate):
  - all PHT counters go to weakly-not-taken (value 2^(CNT_W-1)-1, i.e. 01 for CNT_W=2).
  - state goes to IDLE; pending_pc goes to 0; both perf counters go to 0.
  - flag, flush_d and flush_e are 0 while reset is high.
- Accept: an event is accepted when ex_valid=1 and state=IDLE. While state=PENDING, ex_valid is ignored (EX is held by the stall), so no PHT update, no counting and no new redirect.
- Mispredict (mp), for an accepted event:
  - mp = ex_is_jump | (ex_is_branch & (ex_taken != ex_pred_taken)).
  - Jumps always redirect, because there is no BTB.
  - ex_is_branch and ex_is_jump both high is illegal; treat the event as a jump.
- Target: tgt = (ex_is_jump | ex_taken) ? ex_target : ex_pc_plus4.
- State machine, IDLE / PENDING:
  - IDLE, accepted mp, stall_d=0: flag=flush_d=flush_e=1 and redirect_pc=tgt in the same cycle (combinational); stay in IDLE.
  - IDLE, accepted mp, stall_d=1: outputs stay 0; pending_pc<=tgt; go to PENDING.
  - PENDING, stall_d=1: outputs stay 0; hold.
  - PENDING, stall_d=0: flag=flush_d=flush_e=1 and redirect_pc=pending_pc; go to IDLE next edge.
  - redirect_pc is don't-care when flag=0 but must be deterministic: it drives tgt in IDLE and pending_pc in PENDING.
- PHT update, on an accepted ex_is_branch event, at the clock edge:
  - index = idx(ex_pc).
  - counter increments on taken, decrements on not-taken, and saturates at 0 and 2^CNT_W-1.
  - The update happens whether or not a stall defers the redirect, and exactly once per event.
- Read during write: the fetch lookup in the same cycle sees the old counter value.
- Perf counters:
  - branch_count increments on each accepted branch; mispredict_count increments on each accepted mp.
  - Both wrap modulo 2^PERF_W.
  - The mispredict is counted at accept time, not at redirect time.
- Reset asserted while PENDING: the pending redirect is dropped and no flag follows reset release.

Test Plan:
- Reset, then pc_f=0x40 -> pred_taken_f=0, both counters 0, flag=0.
- Branch at pc 0x40, taken, pred=0, target 0x100, stall_d=0 -> same cycle flag=flush_d=flush_e=1, redirect_pc=0x100; PHT[16]=2, so next-cycle pred_taken_f(0x40)=1; mispredict_count=1, branch_count=1.
- Same branch resolved taken 3 more times with the correct pred=1 -> counter saturates at 3, no flag; one not-taken -> counter=2, pred stays 1, flag=1, redirect_pc=ex_pc_plus4=0x44.
- Jump with stall_d=1 for 3 cycles, target 0x200 -> flag=0 for 3 cycles; flag=1 and redirect_pc=0x200 in the first stall_d=0 cycle; ex_valid held during the stall causes no double count (mispredict_count +1).
- Reset asserted while PENDING -> after release, flag stays 0, PHT is all 01, counters are 0.
- PERF_W=4, 16 jumps -> mispredict_count wraps to 0; PHT_ENTRIES=4 aliasing: pc 0x0 and 0x10 share an entry and updates accumulate.

Source files
------------

// File: rtl/branch_predict_resolver_if.sv
// Fetch-lookup, execute-resolve and redirect/perf bundle between the pipeline and the branch resolver.
interface branch_predict_resolver_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned PERF_W = 32
);
    logic [XLEN-1:0]   pc_f;
    logic              pred_taken_f;
    logic              ex_valid;
    logic              ex_is_branch;
    logic              ex_is_jump;
    logic              ex_taken;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_target;
    logic [XLEN-1:0]   ex_pc_plus4;
    logic              stall_d;
    logic              flag;
    logic [XLEN-1:0]   redirect_pc;
    logic              flush_d;
    logic              flush_e;
    logic [PERF_W-1:0] branch_count;
    logic [PERF_W-1:0] mispredict_count;

    modport master (
        output pc_f, ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken,
               ex_pc, ex_target, ex_pc_plus4, stall_d,
        input  pred_taken_f, flag, redirect_pc, flush_d, flush_e,
               branch_count, mispredict_count
    );

    modport slave (
        input  pc_f, ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken,
               ex_pc, ex_target, ex_pc_plus4, stall_d,
        output pred_taken_f, flag, redirect_pc, flush_d, flush_e,
               branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_predict_resolver.sv
// PHT-based branch predictor with execute-stage resolution, stall-deferred redirect and perf counters.
module branch_predict_resolver #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned PHT_ENTRIES = 64,
    parameter int unsigned IDX_LSB     = 2,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned PERF_W      = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    branch_predict_resolver_if.slave  bp
);

    localparam int unsigned IDX_W = $clog2(PHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

    // Elaboration-time parameter sanity.
    if (PHT_ENTRIES < 2 || (PHT_ENTRIES & (PHT_ENTRIES - 1)) != 0) begin : g_bad_pht
        $error("PHT_ENTRIES must be a power of two and at least 2");
    end
    if (CNT_W < 2) begin : g_bad_cnt
        $error("CNT_W must be at least 2");
    end
    if (IDX_LSB + IDX_W > XLEN) begin : g_bad_idx
        $error("PHT index field exceeds XLEN");
    end

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  pht [PHT_ENTRIES];
    logic [XLEN-1:0]   pending_pc_q;
    logic [PERF_W-1:0] branch_count_q;
    logic [PERF_W-1:0] mispredict_count_q;

    logic [IDX_W-1:0]  f_idx;
    logic [IDX_W-1:0]  ex_idx;
    logic [CNT_W-1:0]  f_cnt;
    logic [CNT_W-1:0]  ex_cnt;
    logic              accept;
    logic              is_jump;
    logic              is_branch;
    logic              mispredict;
    logic [XLEN-1:0]   tgt;
    logic              fire;
    logic              defer;
    logic [XLEN-1:0]   redirect_pc_c;
    logic              unused_pc_bits;

    assign f_idx  = bp.pc_f[IDX_LSB +: IDX_W];
    assign ex_idx = bp.ex_pc[IDX_LSB +: IDX_W];
    assign f_cnt  = pht[f_idx];
    assign ex_cnt = pht[ex_idx];

    // Only the index field of the PCs takes part in the lookup.
    assign unused_pc_bits = ^{bp.pc_f, bp.ex_pc};

    assign bp.pred_taken_f = f_cnt[CNT_W-1];

    // EX is frozen while a redirect is pending, so its event is ignored then.
    assign accept     = bp.ex_valid && (state_q == S_IDLE);
    assign is_jump    = bp.ex_is_jump;
    assign is_branch  = bp.ex_is_branch && !bp.ex_is_jump;
    assign mispredict = is_jump || (is_branch && (bp.ex_taken != bp.ex_pred_taken));
    assign tgt        = (bp.ex_is_jump || bp.ex_taken) ? bp.ex_target : bp.ex_pc_plus4;

    // Next-state and redirect generation.
    always_comb begin
        state_d       = state_q;
        fire          = 1'b0;
        defer         = 1'b0;
        redirect_pc_c = tgt;
        case (state_q)
            S_IDLE: begin
                if (accept && mispredict) begin
                    if (bp.stall_d) begin
                        defer   = 1'b1;
                        state_d = S_PENDING;
                    end else begin
                        fire = 1'b1;
                    end
                end
            end
            S_PENDING: begin
                redirect_pc_c = pending_pc_q;
                if (!bp.stall_d) begin
                    fire    = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
        if (reset) begin
            fire = 1'b0;
        end
    end

    assign bp.flag             = fire;
    assign bp.flush_d          = fire;
    assign bp.flush_e          = fire;
    assign bp.redirect_pc      = redirect_pc_c;
    assign bp.branch_count     = branch_count_q;
    assign bp.mispredict_count = mispredict_count_q;

    // State, pending target, PHT training and perf counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            pending_pc_q       <= '0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht[i] <= CNT_WNT;
            end
        end else begin
            state_q <= state_d;
            if (defer) begin
                pending_pc_q <= tgt;
            end
            if (accept && is_branch) begin
                branch_count_q <= branch_count_q + PERF_W'(1);
                if (bp.ex_taken) begin
                    if (ex_cnt != CNT_MAX) begin
                        pht[ex_idx] <= ex_cnt + CNT_W'(1);
                    end
                end else if (ex_cnt != '0) begin
                    pht[ex_idx] <= ex_cnt - CNT_W'(1);
                end
            end
            if (accept && mispredict) begin
                mispredict_count_q <= mispredict_count_q + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolver.sv
// Directed, table-driven bench for branch_predict_resolver: default build plus a small PHT/PERF_W build.
module tb_branch_predict_resolver;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_predict_resolver_if #(.XLEN(32), .PERF_W(32)) bus_big ();
    branch_predict_resolver_if #(.XLEN(32), .PERF_W(4))  bus_small ();

    branch_predict_resolver #(
        .XLEN(32), .PHT_ENTRIES(64), .IDX_LSB(2), .CNT_W(2), .PERF_W(32)
    ) u_big (
        .clk   (clk),
        .reset (reset),
        .bp    (bus_big.slave)
    );

    branch_predict_resolver #(
        .XLEN(32), .PHT_ENTRIES(4), .IDX_LSB(2), .CNT_W(2), .PERF_W(4)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .bp    (bus_small.slave)
    );

    typedef struct {
        bit          dut;
        bit          valid, br, jmp, tk, pred, stall;
        logic [31:0] pc, tgt, p4, pcf;
        bit          e_flag;
        logic [31:0] e_rpc;
        bit          e_pred;
        logic [31:0] e_bc, e_mc;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(int dut, int valid, int br, int jmp, int tk, int pred, int stall,
                                int pc, int tgt, int p4, int pcf,
                                int e_flag, int e_rpc, int e_pred, int e_bc, int e_mc);
        vec_t v;
        v.dut = (dut != 0);     v.valid = (valid != 0); v.br = (br != 0);
        v.jmp = (jmp != 0);     v.tk = (tk != 0);       v.pred = (pred != 0);
        v.stall = (stall != 0);
        v.pc = 32'(pc);         v.tgt = 32'(tgt);       v.p4 = 32'(p4);   v.pcf = 32'(pcf);
        v.e_flag = (e_flag != 0); v.e_rpc = 32'(e_rpc); v.e_pred = (e_pred != 0);
        v.e_bc = 32'(e_bc);     v.e_mc = 32'(e_mc);
        return v;
    endfunction

    task automatic set_idle();
        bus_big.pc_f = '0;   bus_big.ex_valid = 1'b0;   bus_big.ex_is_branch = 1'b0;
        bus_big.ex_is_jump = 1'b0; bus_big.ex_taken = 1'b0; bus_big.ex_pred_taken = 1'b0;
        bus_big.ex_pc = '0;  bus_big.ex_target = '0;    bus_big.ex_pc_plus4 = '0;
        bus_big.stall_d = 1'b0;
        bus_small.pc_f = '0; bus_small.ex_valid = 1'b0; bus_small.ex_is_branch = 1'b0;
        bus_small.ex_is_jump = 1'b0; bus_small.ex_taken = 1'b0; bus_small.ex_pred_taken = 1'b0;
        bus_small.ex_pc = '0; bus_small.ex_target = '0; bus_small.ex_pc_plus4 = '0;
        bus_small.stall_d = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        set_idle();
        if (!v.dut) begin
            bus_big.pc_f = v.pcf;       bus_big.ex_valid = v.valid;  bus_big.ex_is_branch = v.br;
            bus_big.ex_is_jump = v.jmp; bus_big.ex_taken = v.tk;     bus_big.ex_pred_taken = v.pred;
            bus_big.ex_pc = v.pc;       bus_big.ex_target = v.tgt;   bus_big.ex_pc_plus4 = v.p4;
            bus_big.stall_d = v.stall;
        end else begin
            bus_small.pc_f = v.pcf;       bus_small.ex_valid = v.valid;  bus_small.ex_is_branch = v.br;
            bus_small.ex_is_jump = v.jmp; bus_small.ex_taken = v.tk;     bus_small.ex_pred_taken = v.pred;
            bus_small.ex_pc = v.pc;       bus_small.ex_target = v.tgt;   bus_small.ex_pc_plus4 = v.p4;
            bus_small.stall_d = v.stall;
        end
    endtask

    task automatic chk(input string what, input int tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", what, tag, act, exp);
        end
    endtask

    // Compare every observable output of the selected DUT against the vector's expectations.
    task automatic check_outs(input vec_t v, input int tag);
        if (!v.dut) begin
            chk("flag", tag, 64'(bus_big.flag), 64'(v.e_flag));
            chk("flush_d", tag, 64'(bus_big.flush_d), 64'(v.e_flag));
            chk("flush_e", tag, 64'(bus_big.flush_e), 64'(v.e_flag));
            if (v.e_flag) chk("redirect_pc", tag, 64'(bus_big.redirect_pc), 64'(v.e_rpc));
            chk("pred_taken_f", tag, 64'(bus_big.pred_taken_f), 64'(v.e_pred));
            chk("branch_count", tag, 64'(bus_big.branch_count), 64'(v.e_bc));
            chk("mispredict_count", tag, 64'(bus_big.mispredict_count), 64'(v.e_mc));
        end else begin
            chk("s_flag", tag, 64'(bus_small.flag), 64'(v.e_flag));
            chk("s_flush_d", tag, 64'(bus_small.flush_d), 64'(v.e_flag));
            chk("s_flush_e", tag, 64'(bus_small.flush_e), 64'(v.e_flag));
            if (v.e_flag) chk("s_redirect_pc", tag, 64'(bus_small.redirect_pc), 64'(v.e_rpc));
            chk("s_pred_taken_f", tag, 64'(bus_small.pred_taken_f), 64'(v.e_pred));
            chk("s_branch_count", tag, 64'(bus_small.branch_count), 64'(v.e_bc));
            chk("s_mispredict_count", tag, 64'(bus_small.mispredict_count), 64'(v.e_mc));
        end
    endtask

    task automatic apply_vec(input vec_t v, input int tag);
        drive(v);
        @(negedge clk);
        check_outs(v, tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Default build: predict, mispredict, saturate, fall-through, illegal br+jmp.
        tbl.push_back(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h40, 0,'h000, 0,0,0));
        tbl.push_back(mk(0, 1,1,0,1,0,0, 'h40, 'h100, 'h44, 'h40, 1,'h100, 0,0,0));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h40, 0,'h000, 1,1,1));
        tbl.push_back(mk(0, 1,1,0,1,1,0, 'h40, 'h100, 'h44, 'h40, 0,'h000, 1,1,1));
        tbl.push_back(mk(0, 1,1,0,1,1,0, 'h40, 'h100, 'h44, 'h40, 0,'h000, 1,2,1));
        tbl.push_back(mk(0, 1,1,0,1,1,0, 'h40, 'h100, 'h44, 'h40, 0,'h000, 1,3,1));
        tbl.push_back(mk(0, 1,1,0,0,1,0, 'h40, 'h100, 'h44, 'h40, 1,'h044, 1,4,1));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h40, 0,'h000, 1,5,2));
        tbl.push_back(mk(0, 1,1,0,0,0,0, 'h80, 'h300, 'h84, 'h80, 0,'h000, 0,5,2));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h80, 0,'h000, 0,6,2));
        tbl.push_back(mk(0, 1,1,1,0,1,0, 'hC0, 'h400, 'hC4, 'hC0, 1,'h400, 0,6,2));
        tbl.push_back(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'hC0, 0,'h000, 0,6,3));
        // Small build (4 entries): pc 0x0 and 0x10 alias, counter floor saturation.
        tbl.push_back(mk(1, 1,1,0,1,0,0, 'h00, 'h500, 'h04, 'h00, 1,'h500, 0,0,0));
        tbl.push_back(mk(1, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h10, 0,'h000, 1,1,1));
        tbl.push_back(mk(1, 1,1,0,1,1,0, 'h10, 'h500, 'h14, 'h10, 0,'h000, 1,1,1));
        tbl.push_back(mk(1, 1,1,0,0,1,0, 'h10, 'h500, 'h14, 'h10, 1,'h014, 1,2,1));
        tbl.push_back(mk(1, 1,1,0,0,1,0, 'h00, 'h500, 'h04, 'h00, 1,'h004, 1,3,2));
        tbl.push_back(mk(1, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h00, 0,'h000, 0,4,3));
        tbl.push_back(mk(1, 1,1,0,0,0,0, 'h00, 'h500, 'h04, 'h00, 0,'h000, 0,4,3));
        tbl.push_back(mk(1, 1,1,0,0,0,0, 'h00, 'h500, 'h04, 'h00, 0,'h000, 0,5,3));
        tbl.push_back(mk(1, 1,1,0,1,0,0, 'h00, 'h500, 'h04, 'h00, 1,'h500, 0,6,3));
        tbl.push_back(mk(1, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h00, 0,'h000, 0,7,4));

        // Flags must stay low while reset is held, even with a live jump.
        reset = 1'b1;
        drive(mk(0, 1,0,1,0,0,0, 'h80, 'h200, 'h84, 'h40, 0,0, 0,0,0));
        @(negedge clk);
        chk("flag_in_reset", 0, 64'(bus_big.flag), 64'd0);
        chk("flush_d_in_reset", 0, 64'(bus_big.flush_d), 64'd0);
        set_idle();
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (!tbl[i].dut) apply_vec(tbl[i], i);
        end

        // Jump deferred by a 3-cycle decode stall; ex_valid stays high throughout.
        for (int i = 0; i < 3; i++) begin
            apply_vec(mk(0, 1,0,1,0,0,1, 'h80, 'h200, 'h84, 'h80, 0,0, 0,6,(i == 0) ? 3 : 4), 100 + i);
        end
        apply_vec(mk(0, 1,0,1,0,0,0, 'h80, 'h200, 'h84, 'h80, 1,'h200, 0,6,4), 103);
        apply_vec(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h80, 0,0, 0,6,4), 104);

        // Reset while a redirect is pending: it must be dropped.
        apply_vec(mk(0, 1,0,1,0,0,1, 'h90, 'h700, 'h94, 'h40, 0,0, 1,6,4), 200);
        drive(mk(0, 1,0,1,0,0,1, 'h90, 'h700, 'h94, 'h40, 0,0, 0,0,0));
        @(negedge clk);
        chk("pending_flag", 201, 64'(bus_big.flag), 64'd0);
        chk("pending_mc", 201, 64'(bus_big.mispredict_count), 64'd5);
        reset = 1'b1;
        #1;
        chk("rst_mc", 202, 64'(bus_big.mispredict_count), 64'd0);
        chk("rst_bc", 202, 64'(bus_big.branch_count), 64'd0);
        bus_big.stall_d = 1'b0;
        #1;
        chk("rst_flag", 203, 64'(bus_big.flag), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_idle();
        apply_vec(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h40, 0,0, 0,0,0), 204);
        apply_vec(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h40, 0,0, 0,0,0), 205);
        // Entry 16 was 10 before reset; one taken from 01 must make it predict taken.
        apply_vec(mk(0, 1,1,0,1,0,0, 'h40, 'h100, 'h44, 'h40, 1,'h100, 0,0,0), 206);
        apply_vec(mk(0, 0,0,0,0,0,0, 'h00, 'h000, 'h00, 'h40, 0,0, 1,1,1), 207);

        // Small build: 16 jumps wrap the 4-bit mispredict counter back to 0.
        for (int i = 0; i < 16; i++) begin
            apply_vec(mk(1, 1,0,1,0,0,0, 'h20, 'h600, 'h24, 'h00, 1,'h600, 0,0,i), 300 + i);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].dut) apply_vec(tbl[i], i);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
